cflog_packer: RTL and testbench
===============================

Name: cflog_packer

Overview:
- Parametrised successor to the combinational CFLog entry formatter.
- Forms each control-flow log entry from a CPU branch event, either a {src,dest} pair or a packed loop counter.
- Loop updates are coalesced in place: consecutive loop reports overwrite the last log slot instead of appending.
- Entries pass through a small write FIFO to the CFLog memory over a valid/ack handshake; log pointer, full and overflow state are exported to the attestation logic.

Parameters:
ADDR_W, 16, PC / address width; entry width is 2*ADDR_W
FIFO_DEPTH, 4, write-buffer depth in entries; power of 2, >= 2
LOG_ENTRIES, 256, CFLog capacity in entries
PTR_W, 8, log index width; equals clog2(LOG_ENTRIES)

Ports:
clk  in  1  system clock
puc_rst  in  1  synchronous active-high reset
ev_valid  in  1  a control-flow event is present this cycle
pc  in  ADDR_W  branch destination
prev_pc  in  ADDR_W  branch source
loop_detect  in  1  event is a loop-counter report
loop_ctr  in  2*ADDR_W  packed loop counter
log_clear  in  1  synchronous restart of the log (attestation done)
mem_wen  out  1  write request valid
mem_addr  out  PTR_W  log slot to write
mem_wdata  out  2*ADDR_W  entry to write
mem_ack  in  1  memory accepted the current write
log_ptr  out  PTR_W+1  entries allocated (0..LOG_ENTRIES)
log_full  out  1  log_ptr == LOG_ENTRIES
fifo_ovf  out  1  sticky: an event was dropped because the FIFO was full
drop_cnt  out  8  dropped-event count, saturates at 255
busy  out  1  FIFO non-empty

Behaviour:
- Reset (puc_rst=1 at a clk edge): FIFO empty, log_ptr=0, last_loop=0, fifo_ovf=0, drop_cnt=0. Consequently mem_wen=0, log_full=0, busy=0; mem_addr and mem_wdata are 0 while empty.
- Entry formation:
  - loop_detect=1: entry = loop_ctr.
  - loop_detect=0: entry = {prev_pc, pc}, with prev_pc in the upper ADDR_W bits.
- Classification of a cycle with ev_valid=1:
  - UPDATE: loop_detect=1 and last_loop=1. Slot = log_ptr-1; log_ptr unchanged.
  - APPEND: every other event. Slot = log_ptr; log_ptr increments by 1.
- Acceptance:
  - An event is dropped if the FIFO is full at the start of the cycle. A pop in the same cycle does not free room for it.
  - An APPEND is also dropped when log_full=1.
  - An UPDATE is still accepted when log_full=1.
- last_loop state:
  - Set by an accepted event with loop_detect=1.
  - Cleared by an accepted event with loop_detect=0, by any dropped event, by reset and by log_clear.
  - A dropped event never allocates a slot.
- Drop accounting: each dropped event increments drop_cnt (saturating at 255). fifo_ovf is set only for FIFO-full drops. A log_full drop raises drop_cnt only.
- Latency: an event accepted at edge N appears as the FIFO head. If the FIFO was empty, mem_wen=1 in the cycle after edge N.
- Write handshake:
  - mem_wen=1 whenever the FIFO is non-empty, with mem_addr/mem_wdata showing the head entry.
  - The head is held stable until a cycle with mem_ack=1; the pop happens at that edge.
  - mem_ack while mem_wen=0 is ignored.
  - Back-to-back writes: the next entry is presented in the cycle after the ack.
- Simultaneous push and pop are allowed when the FIFO is not full; occupancy is then unchanged.
- log_clear has priority over events and acks in the same cycle:
  - FIFO flushed, any in-flight write abandoned.
  - log_ptr=0, last_loop=0, fifo_ovf=0, drop_cnt=0.
  - mem_wen=0 from the next cycle.
  - An event in the clear cycle is ignored and not counted.
- Reset mid-write behaves like log_clear.
- log_ptr never exceeds LOG_ENTRIES and does not wrap.
- log_full and busy are combinational from state.

Test Plan:
- Three non-loop events (prev_pc/pc = 0xE000/0xE010, 0xE020/0xE100, 0xE104/0xE200), mem_ack held at 1 -> writes slots 0,1,2 with mem_wdata 0xE000E010, 0xE020E100, 0xE104E200; log_ptr=3; mem_wen first high one cycle after the first event.
- Non-loop event, then loop_ctr 0x00010002, then 0x00010003, 0x00010004 -> slot 1 written three times (last value 0x00010004); log_ptr=2.
- mem_ack held at 0, 6 consecutive events with FIFO_DEPTH=4 -> 4 accepted, fifo_ovf=1, drop_cnt=2, log_ptr=4. Release ack -> slots 0..3 drained in order, busy=0 after the 4th ack.
- LOG_ENTRIES=4: 5 non-loop events, then a loop event, then a loop event -> 5th dropped, log_full=1, drop_cnt=1, fifo_ovf=0. The first loop event is also dropped (APPEND at full, clears last_loop); the second loop event is likewise dropped.
- log_clear asserted with 2 entries queued, mem_ack=0, and ev_valid=1 in the same cycle -> next cycle mem_wen=0, log_ptr=0, drop_cnt=0; a following event writes slot 0.

Source files
------------

// File: rtl/cflog_packer.sv
`default_nettype none
// ============================================================================
//  Module   : cflog_packer
//  Purpose  : Builds control-flow log entries from CPU branch events, either a
//             {src,dest} pair or a packed loop counter. Consecutive loop
//             reports coalesce into the last log slot. Entries are buffered
//             in a small write FIFO and handed to the CFLog memory over a
//             valid/ack handshake.
//  Ports    : clk, puc_rst         - clock, synchronous active-high reset
//             ev_valid, pc,
//             prev_pc, loop_detect,
//             loop_ctr             - branch event and its payload
//             log_clear            - synchronous restart of the log
//             mem_wen, mem_addr,
//             mem_wdata, mem_ack   - write request to the CFLog memory
//             log_ptr, log_full    - allocated entries / log exhausted
//             fifo_ovf, drop_cnt   - sticky overflow flag, dropped events
//             busy                 - write FIFO non-empty
//  Revision : 1.0 - initial release
// ============================================================================
module cflog_packer #(
    parameter int ADDR_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int LOG_ENTRIES = 256,
    parameter int PTR_W       = 8
) (
    input  logic                  clk,
    input  logic                  puc_rst,
    input  logic                  ev_valid,
    input  logic [ADDR_W-1:0]     pc,
    input  logic [ADDR_W-1:0]     prev_pc,
    input  logic                  loop_detect,
    input  logic [2*ADDR_W-1:0]   loop_ctr,
    input  logic                  log_clear,
    output logic                  mem_wen,
    output logic [PTR_W-1:0]      mem_addr,
    output logic [2*ADDR_W-1:0]   mem_wdata,
    input  logic                  mem_ack,
    output logic [PTR_W:0]        log_ptr,
    output logic                  log_full,
    output logic                  fifo_ovf,
    output logic [7:0]            drop_cnt,
    output logic                  busy
);

    localparam int                 c_ENTRY_W   = 2 * ADDR_W;
    localparam int                 c_FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam logic [c_FIFO_AW:0] c_FIFO_FULL = (c_FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_FIFO_AW:0] c_CNT_ONE   = (c_FIFO_AW + 1)'(1);
    localparam logic [c_FIFO_AW-1:0] c_FPTR_ONE = c_FIFO_AW'(1);
    localparam logic [PTR_W:0]     c_LOG_CAP   = (PTR_W + 1)'(LOG_ENTRIES);
    localparam logic [PTR_W:0]     c_LPTR_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]   c_SLOT_ONE  = PTR_W'(1);

    // Write buffer storage (slot index and entry payload per element)
    logic [PTR_W-1:0]     r_fifo_addr [0:FIFO_DEPTH-1];
    logic [c_ENTRY_W-1:0] r_fifo_data [0:FIFO_DEPTH-1];
    logic [c_FIFO_AW-1:0] r_rd_ptr;
    logic [c_FIFO_AW-1:0] r_wr_ptr;
    logic [c_FIFO_AW:0]   r_count;

    logic [PTR_W:0]       r_log_ptr;
    logic                 r_last_loop;
    logic                 r_fifo_ovf;
    logic [7:0]           r_drop_cnt;

    logic                 w_restart;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_log_full;
    logic                 w_is_update;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_drop_fifo;
    logic [c_ENTRY_W-1:0] w_entry;
    logic [PTR_W-1:0]     w_slot;

    // Reset and log_clear share one restart path and override everything.
    assign w_restart    = puc_rst | log_clear;
    assign w_fifo_full  = (r_count == c_FIFO_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign w_log_full   = (r_log_ptr == c_LOG_CAP);

    // A loop report directly following an accepted loop report rewrites the
    // previous slot instead of allocating a new one.
    assign w_is_update  = loop_detect & r_last_loop;

    // FIFO room is judged on start-of-cycle occupancy only; a same-cycle pop
    // does not make room. Updates are allowed into a full log because they
    // consume no new slot.
    assign w_push      = ev_valid & ~w_restart & ~w_fifo_full
                       & (w_is_update | ~w_log_full);
    assign w_drop      = ev_valid & ~w_restart & ~w_push;
    assign w_drop_fifo = w_drop & w_fifo_full;

    assign w_pop = ~w_fifo_empty & mem_ack;

    assign w_entry = loop_detect ? loop_ctr : {prev_pc, pc};

    // LOG_ENTRIES is a power of two, so the low PTR_W bits of log_ptr minus
    // one give the last slot even when log_ptr == LOG_ENTRIES.
    assign w_slot = w_is_update ? (r_log_ptr[PTR_W-1:0] - c_SLOT_ONE)
                                : r_log_ptr[PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_slot;
            r_fifo_data[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (w_restart) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_log_ptr   <= '0;
            r_last_loop <= 1'b0;
            r_fifo_ovf  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_FPTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_FPTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_push && !w_is_update) begin
                r_log_ptr <= r_log_ptr + c_LPTR_ONE;
            end

            if (w_push) begin
                r_last_loop <= loop_detect;
            end else if (w_drop) begin
                r_last_loop <= 1'b0;
            end

            if (w_drop_fifo) begin
                r_fifo_ovf <= 1'b1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign mem_wen   = ~w_fifo_empty;
    assign mem_addr  = w_fifo_empty ? '0 : r_fifo_addr[r_rd_ptr];
    assign mem_wdata = w_fifo_empty ? '0 : r_fifo_data[r_rd_ptr];
    assign log_ptr   = r_log_ptr;
    assign log_full  = w_log_full;
    assign fifo_ovf  = r_fifo_ovf;
    assign drop_cnt  = r_drop_cnt;
    assign busy      = ~w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_cflog_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cflog_packer
//  Purpose  : Self-checking bench for cflog_packer. Two instances share the
//             stimulus: A with the default 256-entry log, B with a 4-entry
//             log. A queue-level reference model tracks both every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cflog_packer;

    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          puc_rst, ev_valid, loop_detect, log_clear, mem_ack;
    logic [AW-1:0] pc, prev_pc;
    logic [31:0]   loop_ctr;

    logic        a_wen, a_ovf, a_full, a_busy;
    logic [7:0]  a_addr, a_drop;
    logic [31:0] a_wdata;
    logic [8:0]  a_ptr;

    logic        b_wen, b_ovf, b_full, b_busy;
    logic [1:0]  b_addr;
    logic [7:0]  b_drop;
    logic [31:0] b_wdata;
    logic [2:0]  b_ptr;

    cflog_packer #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .LOG_ENTRIES(256), .PTR_W(8)) dut_a (
        .clk(clk), .puc_rst(puc_rst), .ev_valid(ev_valid), .pc(pc), .prev_pc(prev_pc),
        .loop_detect(loop_detect), .loop_ctr(loop_ctr), .log_clear(log_clear),
        .mem_wen(a_wen), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_ack(mem_ack),
        .log_ptr(a_ptr), .log_full(a_full), .fifo_ovf(a_ovf), .drop_cnt(a_drop),
        .busy(a_busy)
    );

    cflog_packer #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .LOG_ENTRIES(4), .PTR_W(2)) dut_b (
        .clk(clk), .puc_rst(puc_rst), .ev_valid(ev_valid), .pc(pc), .prev_pc(prev_pc),
        .loop_detect(loop_detect), .loop_ctr(loop_ctr), .log_clear(log_clear),
        .mem_wen(b_wen), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_ack(mem_ack),
        .log_ptr(b_ptr), .log_full(b_full), .fifo_ovf(b_ovf), .drop_cnt(b_drop),
        .busy(b_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per instance, an ordered list of pending writes plus
    // the log bookkeeping, updated from the rules of the block.
    int          m_cap   [2] = '{256, 4};
    int          m_cnt   [2];
    int          m_addr  [2][DEPTH];
    logic [31:0] m_data  [2][DEPTH];
    int          m_ptr   [2];
    bit          m_last  [2];
    bit          m_ovf   [2];
    int          m_drops [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_drop(input int k);
        m_last[k] = 1'b0;
        if (m_drops[k] < 255) m_drops[k]++;
    endtask

    task automatic model_step(input int k);
        int  n0;
        bit  upd;
        if (puc_rst || log_clear) begin
            m_cnt[k] = 0; m_ptr[k] = 0; m_last[k] = 1'b0;
            m_ovf[k] = 1'b0; m_drops[k] = 0;
        end else begin
            n0 = m_cnt[k];
            if (n0 > 0 && mem_ack) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    m_addr[k][i] = m_addr[k][i+1];
                    m_data[k][i] = m_data[k][i+1];
                end
                m_cnt[k]--;
            end
            if (ev_valid) begin
                upd = loop_detect && m_last[k];
                if (n0 == DEPTH) begin
                    m_ovf[k] = 1'b1;
                    model_drop(k);
                end else if (!upd && m_ptr[k] == m_cap[k]) begin
                    model_drop(k);
                end else begin
                    m_addr[k][m_cnt[k]] = upd ? m_ptr[k] - 1 : m_ptr[k];
                    m_data[k][m_cnt[k]] = loop_detect ? loop_ctr : {prev_pc, pc};
                    m_cnt[k]++;
                    if (!upd) m_ptr[k]++;
                    m_last[k] = loop_detect;
                end
            end
        end
    endtask

    task automatic chk_model();
        for (int k = 0; k < 2; k++) begin
            bit          e_wen;
            int          e_addr;
            logic [31:0] e_data;
            e_wen  = (m_cnt[k] > 0);
            e_addr = e_wen ? m_addr[k][0] : 0;
            e_data = e_wen ? m_data[k][0] : 32'h0;
            if (k == 0) begin
                chk("A.wen",   a_wen,   e_wen);
                chk("A.addr",  a_addr,  e_addr);
                chk("A.wdata", a_wdata, e_data);
                chk("A.ptr",   a_ptr,   m_ptr[k]);
                chk("A.full",  a_full,  m_ptr[k] == m_cap[k]);
                chk("A.ovf",   a_ovf,   m_ovf[k]);
                chk("A.drop",  a_drop,  m_drops[k]);
                chk("A.busy",  a_busy,  e_wen);
            end else begin
                chk("B.wen",   b_wen,   e_wen);
                chk("B.addr",  b_addr,  e_addr);
                chk("B.wdata", b_wdata, e_data);
                chk("B.ptr",   b_ptr,   m_ptr[k]);
                chk("B.full",  b_full,  m_ptr[k] == m_cap[k]);
                chk("B.ovf",   b_ovf,   m_ovf[k]);
                chk("B.drop",  b_drop,  m_drops[k]);
                chk("B.busy",  b_busy,  e_wen);
            end
        end
    endtask

    // One clock: inputs already applied; update model at the edge, compare
    // shortly after it.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk_model();
    endtask

    task automatic idle(input bit ack);
        ev_valid = 0; loop_detect = 0; log_clear = 0; puc_rst = 0; mem_ack = ack;
    endtask

    task automatic ev_np(input logic [15:0] src, input logic [15:0] dst);
        ev_valid = 1; loop_detect = 0; prev_pc = src; pc = dst;
    endtask

    task automatic ev_loop(input logic [31:0] ctr);
        ev_valid = 1; loop_detect = 1; loop_ctr = ctr;
    endtask

    task automatic do_clear();
        idle(1'b0); log_clear = 1; cycle(); log_clear = 0;
    endtask

    typedef struct {
        bit          clr;
        bit          ev;
        bit          ld;
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] ctr;
        bit          ack;
        bit          exp_wen;
        int          exp_addr;
        logic [31:0] exp_data;
        int          exp_ptr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        puc_rst = 1; ev_valid = 0; loop_detect = 0; log_clear = 0; mem_ack = 0;
        pc = '0; prev_pc = '0; loop_ctr = '0;
        cycle();
        chk("rst.wen",  a_wen,  0);
        chk("rst.ptr",  a_ptr,  0);
        chk("rst.busy", a_busy, 0);
        chk("rst.full", b_full, 0);
        puc_rst = 0;

        // Non-loop appends, then loop coalescing, with ack held high
        tbl[0]  = '{1, 0, 0, 16'h0,    16'h0,    32'h0,        1, 0, 0, 32'h0,        0};
        tbl[1]  = '{0, 1, 0, 16'hE000, 16'hE010, 32'h0,        1, 1, 0, 32'hE000E010, 1};
        tbl[2]  = '{0, 1, 0, 16'hE020, 16'hE100, 32'h0,        1, 1, 1, 32'hE020E100, 2};
        tbl[3]  = '{0, 1, 0, 16'hE104, 16'hE200, 32'h0,        1, 1, 2, 32'hE104E200, 3};
        tbl[4]  = '{0, 0, 0, 16'h0,    16'h0,    32'h0,        1, 0, 0, 32'h0,        3};
        tbl[5]  = '{1, 0, 0, 16'h0,    16'h0,    32'h0,        1, 0, 0, 32'h0,        0};
        tbl[6]  = '{0, 1, 0, 16'h1000, 16'h1004, 32'h0,        1, 1, 0, 32'h10001004, 1};
        tbl[7]  = '{0, 1, 1, 16'h0,    16'h0,    32'h00010002, 1, 1, 1, 32'h00010002, 2};
        tbl[8]  = '{0, 1, 1, 16'h0,    16'h0,    32'h00010003, 1, 1, 1, 32'h00010003, 2};
        tbl[9]  = '{0, 1, 1, 16'h0,    16'h0,    32'h00010004, 1, 1, 1, 32'h00010004, 2};
        tbl[10] = '{0, 0, 0, 16'h0,    16'h0,    32'h0,        1, 0, 0, 32'h0,        2};
        for (int i = 0; i < 11; i++) begin
            log_clear = tbl[i].clr; ev_valid = tbl[i].ev; loop_detect = tbl[i].ld;
            prev_pc = tbl[i].src; pc = tbl[i].dst; loop_ctr = tbl[i].ctr;
            mem_ack = tbl[i].ack;
            cycle();
            chk($sformatf("tbl%0d.wen", i),   a_wen,   tbl[i].exp_wen);
            chk($sformatf("tbl%0d.addr", i),  a_addr,  tbl[i].exp_addr);
            chk($sformatf("tbl%0d.wdata", i), a_wdata, tbl[i].exp_data);
            chk($sformatf("tbl%0d.ptr", i),   a_ptr,   tbl[i].exp_ptr);
        end

        // FIFO overflow with ack stalled, then drain in order
        do_clear();
        mem_ack = 0;
        for (int i = 0; i < 6; i++) begin
            ev_np(16'(16'h2000 + i), 16'(16'h3000 + i));
            cycle();
        end
        idle(1'b0);
        chk("ovf.flag", a_ovf,  1);
        chk("ovf.drop", a_drop, 2);
        chk("ovf.ptr",  a_ptr,  4);
        mem_ack = 1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.addr", i),  a_addr,  i);
            chk($sformatf("drain%0d.wdata", i), a_wdata, {16'(16'h2000 + i), 16'(16'h3000 + i)});
            cycle();
        end
        chk("drain.busy", a_busy, 0);

        // Log-full drops on the 4-entry instance
        do_clear();
        mem_ack = 1;
        for (int i = 0; i < 5; i++) begin
            ev_np(16'(16'h4000 + i), 16'(16'h5000 + i));
            cycle();
        end
        chk("lf.full", b_full, 1);
        chk("lf.drop", b_drop, 1);
        chk("lf.ovf",  b_ovf,  0);
        chk("lf.ptr",  b_ptr,  4);
        ev_loop(32'h00070001); cycle();
        chk("lf.loop1.drop", b_drop, 2);
        ev_loop(32'h00070002); cycle();
        chk("lf.loop2.drop", b_drop, 3);
        chk("lf.loop2.ptr",  b_ptr,  4);
        idle(1'b1); cycle();

        // log_clear with queued entries and a colliding event
        do_clear();
        mem_ack = 0;
        ev_np(16'h6000, 16'h6004); cycle();
        ev_np(16'h6010, 16'h6014); cycle();
        log_clear = 1; ev_np(16'h6020, 16'h6024); cycle();
        chk("clr.wen",  a_wen,  0);
        chk("clr.ptr",  a_ptr,  0);
        chk("clr.drop", a_drop, 0);
        log_clear = 0; mem_ack = 1; ev_np(16'h7000, 16'h7004); cycle();
        chk("clr.next.wen",   a_wen,   1);
        chk("clr.next.addr",  a_addr,  0);
        chk("clr.next.wdata", a_wdata, 32'h70007004);
        idle(1'b1); cycle();

        // Reset in the middle of pending writes
        mem_ack = 0;
        ev_np(16'h8000, 16'h8004); cycle();
        ev_np(16'h8010, 16'h8014); cycle();
        puc_rst = 1; cycle();
        chk("rstmid.wen", a_wen, 0);
        chk("rstmid.ptr", a_ptr, 0);
        idle(1'b0);

        // drop_cnt saturation
        do_clear();
        mem_ack = 0;
        for (int i = 0; i < 300; i++) begin
            ev_np(16'(i), 16'(i + 1));
            cycle();
        end
        chk("sat.drop", a_drop, 255);
        chk("sat.ovf",  a_ovf,  1);
        idle(1'b1);

        // Randomised traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            int ack_pct;
            ack_pct    = ((i / 200) % 2 == 0) ? 70 : 20;
            puc_rst    = ($urandom_range(0, 499) == 0);
            log_clear  = ($urandom_range(0, 149) == 0);
            ev_valid   = ($urandom_range(0, 99) < 70);
            loop_detect = ($urandom_range(0, 99) < 40);
            pc         = 16'($urandom);
            prev_pc    = 16'($urandom);
            loop_ctr   = $urandom;
            mem_ack    = ($urandom_range(0, 99) < ack_pct);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
